// File: rtl/axi4_lite_write_slave_responder.sv
// axi4_lite_write_slave_responder: AXI4-Lite write slave with AW/W queues, delay knobs and a byte-strobed register file
module axi4_lite_write_slave_responder #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int DELAY_WIDTH = 5,
    parameter bit DEFAULT_READY = 1'b1,
    parameter logic [ADDRESS_WIDTH-1:0] MIN_ADDRESS = 'h00,
    parameter logic [ADDRESS_WIDTH-1:0] MAX_ADDRESS = 'hFF,
    localparam int STRB_WIDTH = DATA_WIDTH / 8,
    localparam int NUM_WORDS = int'((MAX_ADDRESS - MIN_ADDRESS + 1) / STRB_WIDTH),
    localparam int INDEX_WIDTH = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [ADDRESS_WIDTH-1:0] awaddr,
    input  logic [2:0]               awprot,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [STRB_WIDTH-1:0]    wstrb,
    input  logic                     wvalid,
    output logic                     wready,
    output logic [1:0]               bresp,
    output logic                     bvalid,
    input  logic                     bready,
    input  logic [DELAY_WIDTH-1:0]   cfg_awready_dly,
    input  logic [DELAY_WIDTH-1:0]   cfg_wready_dly,
    input  logic [DELAY_WIDTH-1:0]   cfg_bvalid_dly,
    input  logic [INDEX_WIDTH-1:0]   dbg_addr,
    output logic [DATA_WIDTH-1:0]    dbg_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int OB = $clog2(STRB_WIDTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] SPAN = MAX_ADDRESS - MIN_ADDRESS;

    logic [ADDRESS_WIDTH-1:0] aw_addr_q [DEPTH];
    logic [2:0]               aw_prot_q [DEPTH];
    logic [DATA_WIDTH-1:0]    w_data_q  [DEPTH];
    logic [STRB_WIDTH-1:0]    w_strb_q  [DEPTH];
    logic [DATA_WIDTH-1:0]    mem       [NUM_WORDS];
    logic [PW-1:0]            aw_wr, aw_rd, w_wr, w_rd;
    logic [PW:0]              aw_cnt, w_cnt;
    logic [DELAY_WIDTH-1:0]   b_cnt;
    logic                     b_pend, aw_hs, w_hs, b_free, commit;
    logic [1:0]               full, rdy, resp;
    logic [ADDRESS_WIDTH-1:0] off;
    logic [INDEX_WIDTH-1:0]   idx;
    logic [2+2*DELAY_WIDTH:0] unused_bits;

    assign unused_bits = {aw_prot_q[aw_rd], cfg_awready_dly, cfg_wready_dly};
    assign aw_hs = awvalid && awready;
    assign w_hs = wvalid && wready;
    assign b_free = bvalid ? bready : !b_pend;
    assign commit = aw_cnt != '0 && w_cnt != '0 && b_free;
    // an address below MIN wraps to a huge offset, so one compare covers both bounds
    assign off = aw_addr_q[aw_rd] - MIN_ADDRESS;
    assign idx = off[OB +: INDEX_WIDTH];
    assign resp = (off > SPAN) ? 2'b11 : (aw_addr_q[aw_rd][OB-1:0] != '0) ? 2'b10 : 2'b00;
    assign dbg_data = mem[dbg_addr];
    assign full = {w_cnt == FULL, aw_cnt == FULL};
    assign awready = rdy[0];
    assign wready = rdy[1];

    generate
        if (DEFAULT_READY) begin : g_fast
            assign rdy = ~full & {2{~areset}};
        end else begin : g_dly
            logic [1:0] vld;
            assign vld = {wvalid, awvalid};
            for (genvar c = 0; c < 2; c++) begin : g_ch
                typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RDY} rdy_t;
                rdy_t st, st_nx;
                logic [DELAY_WIDTH-1:0] cnt, cnt_nx, dly;
                assign dly = (c == 0) ? cfg_awready_dly : cfg_wready_dly;
                assign rdy[c] = st == R_RDY && !full[c];
                // ready-delay state register
                always_ff @(posedge aclk or posedge areset) begin
                    if (areset) begin
                        st <= R_IDLE;
                        cnt <= '0;
                    end else begin
                        st <= st_nx;
                        cnt <= cnt_nx;
                    end
                end
                // wait out the programmed delay, then hold ready until the handshake
                always_comb begin
                    st_nx = st;
                    cnt_nx = cnt;
                    case (st)
                        R_IDLE: if (vld[c] && !full[c]) begin
                            st_nx = (dly == '0) ? R_RDY : R_WAIT;
                            cnt_nx = dly - DELAY_WIDTH'(1);
                        end
                        R_WAIT: begin
                            st_nx = (cnt == '0) ? R_RDY : R_WAIT;
                            cnt_nx = cnt - DELAY_WIDTH'(1);
                        end
                        default: if (vld[c] && rdy[c]) st_nx = R_IDLE;
                    endcase
                end
            end
        end
    endgenerate

    // queue storage only matters behind the counters, so it carries no reset
    always_ff @(posedge aclk) begin
        if (aw_hs) begin
            aw_addr_q[aw_wr] <= awaddr;
            aw_prot_q[aw_wr] <= awprot;
        end
        if (w_hs) begin
            w_data_q[w_wr] <= wdata;
            w_strb_q[w_wr] <= wstrb;
        end
    end

    // queue bookkeeping, B-channel sequencing and strobed register-file writes
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            aw_wr <= '0;
            aw_rd <= '0;
            w_wr <= '0;
            w_rd <= '0;
            aw_cnt <= '0;
            w_cnt <= '0;
            bvalid <= 1'b0;
            bresp <= 2'b00;
            b_pend <= 1'b0;
            b_cnt <= '0;
            for (int i = 0; i < NUM_WORDS; i++) mem[i] <= '0;
        end else begin
            aw_wr <= aw_wr + PW'(aw_hs);
            w_wr <= w_wr + PW'(w_hs);
            aw_rd <= aw_rd + PW'(commit);
            w_rd <= w_rd + PW'(commit);
            aw_cnt <= aw_cnt + (PW+1)'(aw_hs) - (PW+1)'(commit);
            w_cnt <= w_cnt + (PW+1)'(w_hs) - (PW+1)'(commit);
            if (commit) begin
                bresp <= resp;
                bvalid <= cfg_bvalid_dly == '0;
                b_pend <= cfg_bvalid_dly != '0;
                b_cnt <= cfg_bvalid_dly - DELAY_WIDTH'(1);
                if (resp == 2'b00)
                    for (int i = 0; i < STRB_WIDTH; i++)
                        if (w_strb_q[w_rd][i]) mem[idx][8*i +: 8] <= w_data_q[w_rd][8*i +: 8];
            end else if (b_pend) begin
                if (b_cnt == '0) begin
                    bvalid <= 1'b1;
                    b_pend <= 1'b0;
                end
                b_cnt <= b_cnt - DELAY_WIDTH'(1);
            end else if (bvalid && bready) begin
                bvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axi4_lite_write_slave_responder.sv
// tb_axi4_lite_write_slave_responder: directed checks of the AXI4-Lite write responder
module tb_axi4_lite_write_slave_responder;
    logic        aclk = 1'b0, areset = 1'b1;
    logic [31:0] awaddr = '0, wdata = '0;
    logic [2:0]  awprot = '0;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
    logic [4:0]  cfg_awready_dly = '0, cfg_wready_dly = '0, cfg_bvalid_dly = '0;
    logic [5:0]  dbg_addr = '0;
    logic        awready, wready, bvalid, awready2, wready2, bvalid2;
    logic [1:0]  bresp, bresp2;
    logic [31:0] dbg_data, dbg_data2;
    int checks = 0, errors = 0;

    always #5 aclk = ~aclk;

    axi4_lite_write_slave_responder u_dut (
        .aclk(aclk), .areset(areset), .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid),
        .awready(awready), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready), .cfg_awready_dly(cfg_awready_dly),
        .cfg_wready_dly(cfg_wready_dly), .cfg_bvalid_dly(cfg_bvalid_dly),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    axi4_lite_write_slave_responder #(.DEFAULT_READY(1'b0)) u_dly (
        .aclk(aclk), .areset(areset), .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid),
        .awready(awready2), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready2),
        .bresp(bresp2), .bvalid(bvalid2), .bready(bready), .cfg_awready_dly(cfg_awready_dly),
        .cfg_wready_dly(cfg_wready_dly), .cfg_bvalid_dly(cfg_bvalid_dly),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data2)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
        tick();
    endtask

    task automatic do_aw(input logic [31:0] a);
        int n = 0;
        awaddr = a;
        awvalid = 1'b1;
        while (!awready && n < 40) begin tick(); n++; end
        if (!awready) begin checks++; errors++; $display("FAIL aw_timeout awready=%b want 1", awready); end
        tick();
        awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        wdata = d;
        wstrb = s;
        wvalid = 1'b1;
        while (!wready && n < 40) begin tick(); n++; end
        if (!wready) begin checks++; errors++; $display("FAIL w_timeout wready=%b want 1", wready); end
        tick();
        wvalid = 1'b0;
    endtask

    task automatic do_pair(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        awaddr = a;
        wdata = d;
        wstrb = s;
        awvalid = 1'b1;
        wvalid = 1'b1;
        while (!(awready && wready) && n < 40) begin tick(); n++; end
        if (!(awready && wready)) begin checks++; errors++; $display("FAIL pair_timeout ready=%b%b want 11", awready, wready); end
        tick();
        awvalid = 1'b0;
        wvalid = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        dbg_addr = 6'd4;
        tick();
        checks++; if ({awready, wready, bvalid, bresp} !== 5'b0) begin errors++; $display("FAIL reset_outputs got %b want 00000", {awready, wready, bvalid, bresp}); end
        checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL reset_mem got %h want 0", dbg_data); end
        areset = 1'b0;
        tick();
        checks++; if ({awready, wready} !== 2'b11) begin errors++; $display("FAIL ready_after_reset got %b want 11", {awready, wready}); end
        checks++; if ({awready2, wready2, bvalid2} !== 3'b0) begin errors++; $display("FAIL dly_idle got %b want 000", {awready2, wready2, bvalid2}); end
    endtask

    task automatic test_same_cycle();
        dbg_addr = 6'd4;
        do_pair(32'h10, 32'hA5A5_5A5A, 4'hF);
        checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL same_cycle_early bvalid=%b want 0", bvalid); end
        tick();
        checks++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin errors++; $display("FAIL same_cycle_b got %b/%b want 1/00", bvalid, bresp); end
        checks++; if (dbg_data !== 32'hA5A5_5A5A) begin errors++; $display("FAIL same_cycle_mem got %h want a5a55a5a", dbg_data); end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL same_cycle_ack bvalid=%b want 0", bvalid); end
    endtask

    task automatic test_w_leads();
        dbg_addr = 6'd8;
        do_w(32'h1122_3344, 4'b0101);
        tick();
        tick();
        checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL w_alone bvalid=%b want 0", bvalid); end
        do_aw(32'h20);
        tick();
        checks++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin errors++; $display("FAIL w_leads_b got %b/%b want 1/00", bvalid, bresp); end
        checks++; if (dbg_data !== 32'h0022_0044) begin errors++; $display("FAIL w_leads_mem got %h want 00220044", dbg_data); end
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic test_decode();
        logic [31:0] ta [7] = '{32'h102, 32'h13, 32'h100, 32'h20, 32'hFC, 32'h00, 32'h22};
        logic [31:0] td [7] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h0BADCAFE, 32'h12345678, 32'hDEADBEEF};
        logic [3:0]  ts [7] = '{4'hF, 4'hF, 4'hF, 4'h0, 4'hF, 4'b1010, 4'hF};
        logic [1:0]  tr [7] = '{2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b10};
        logic [5:0]  ti [7] = '{6'd0, 6'd4, 6'd0, 6'd8, 6'd63, 6'd0, 6'd8};
        logic [31:0] tw [7] = '{32'h0, 32'hA5A55A5A, 32'h0, 32'h00220044, 32'h0BADCAFE, 32'h12005600, 32'h00220044};
        for (int i = 0; i < 7; i++) begin
            do_aw(ta[i]);
            do_w(td[i], ts[i]);
            tick();
            checks++; if (bvalid !== 1'b1 || bresp !== tr[i]) begin errors++; $display("FAIL decode_%0d got %b/%b want 1/%b", i, bvalid, bresp, tr[i]); end
            bready = 1'b1;
            tick();
            bready = 1'b0;
            dbg_addr = ti[i];
            #1;
            checks++; if (dbg_data !== tw[i]) begin errors++; $display("FAIL decode_mem_%0d got %h want %h", i, dbg_data, tw[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] pa [6] = '{32'h40, 32'h45, 32'h48, 32'h104, 32'h50, 32'h54};
        logic [1:0]  pr [6] = '{2'b00, 2'b10, 2'b00, 2'b11, 2'b00, 2'b00};
        logic [5:0]  wi [5] = '{6'd16, 6'd17, 6'd18, 6'd20, 6'd21};
        logic [31:0] wv [5] = '{32'h1000, 32'h0, 32'h1002, 32'h1004, 32'h1005};
        do_reset();
        bready = 1'b0;
        fork
            for (int k = 0; k < 6; k++) do_pair(pa[k], 32'h1000 + k, 4'hF);
            begin
                repeat (10) begin
                    tick();
                    if (bvalid) begin
                        checks++; if (bresp !== 2'b00) begin errors++; $display("FAIL bp_stable got %b want 00", bresp); end
                    end
                end
                checks++; if ({awready, wready, bvalid} !== 3'b001) begin errors++; $display("FAIL bp_full got %b want 001", {awready, wready, bvalid}); end
                bready = 1'b1;
                for (int k = 0; k < 6; k++) begin
                    int n = 0;
                    while (!bvalid && n < 40) begin tick(); n++; end
                    checks++; if (bvalid !== 1'b1 || bresp !== pr[k]) begin errors++; $display("FAIL bp_resp_%0d got %b/%b want 1/%b", k, bvalid, bresp, pr[k]); end
                    tick();
                end
            end
        join
        bready = 1'b0;
        tick();
        checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL bp_extra bvalid=%b want 0", bvalid); end
        for (int i = 0; i < 5; i++) begin
            dbg_addr = wi[i];
            #1;
            checks++; if (dbg_data !== wv[i]) begin errors++; $display("FAIL bp_mem_%0d got %h want %h", wi[i], dbg_data, wv[i]); end
        end
    endtask

    task automatic test_delays();
        do_reset();
        cfg_awready_dly = 5'd3;
        cfg_wready_dly = 5'd0;
        cfg_bvalid_dly = 5'd2;
        dbg_addr = 6'd12;
        awaddr = 32'h30;
        awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (awready2 !== (i == 4)) begin errors++; $display("FAIL dly_awready_%0d got %b want %b", i, awready2, i == 4); end
            if (i < 4) tick();
        end
        tick();
        awvalid = 1'b0;
        checks++; if (awready2 !== 1'b0) begin errors++; $display("FAIL dly_aw_drop got %b want 0", awready2); end
        wdata = 32'hCAFE_F00D;
        wstrb = 4'hF;
        wvalid = 1'b1;
        checks++; if (wready2 !== 1'b0) begin errors++; $display("FAIL dly_wready_early got %b want 0", wready2); end
        tick();
        checks++; if (wready2 !== 1'b1) begin errors++; $display("FAIL dly_wready got %b want 1", wready2); end
        tick();
        wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bvalid2 !== (i == 3)) begin errors++; $display("FAIL dly_bvalid_%0d got %b want %b", i, bvalid2, i == 3); end
            checks++; if (dbg_data2 !== ((i == 0) ? 32'h0 : 32'hCAFE_F00D)) begin errors++; $display("FAIL dly_mem_%0d got %h", i, dbg_data2); end
            if (i < 3) tick();
        end
        checks++; if (bresp2 !== 2'b00) begin errors++; $display("FAIL dly_bresp got %b want 00", bresp2); end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        checks++; if (bvalid2 !== 1'b0) begin errors++; $display("FAIL dly_ack got %b want 0", bvalid2); end
        cfg_awready_dly = '0;
        cfg_bvalid_dly = '0;
    endtask

    task automatic test_async_reset();
        do_reset();
        dbg_addr = 6'd24;
        do_pair(32'h60, 32'h77, 4'hF);
        tick();
        do_pair(32'h64, 32'h88, 4'hF);
        do_pair(32'h68, 32'h99, 4'hF);
        checks++; if (bvalid !== 1'b1 || dbg_data !== 32'h77) begin errors++; $display("FAIL pre_reset got %b/%h want 1/00000077", bvalid, dbg_data); end
        #2 areset = 1'b1;
        #1;
        checks++; if ({awready, wready, bvalid, bresp} !== 5'b0) begin errors++; $display("FAIL async_outputs got %b want 00000", {awready, wready, bvalid, bresp}); end
        checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL async_mem got %h want 0", dbg_data); end
        tick();
        areset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL stale_b_%0d bvalid=%b want 0", i, bvalid); end
        end
        checks++; if ({awready, wready} !== 2'b11) begin errors++; $display("FAIL post_reset_ready got %b want 11", {awready, wready}); end
    endtask

    initial begin
        test_reset();
        test_same_cycle();
        test_w_leads();
        test_decode();
        test_backpressure();
        test_delays();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end
endmodule
